// File: rtl/intr_pkg.sv
// Shared types and default parameters for interrupt-source conditioning blocks.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-stage flop synchronizer for bringing an asynchronous level into the CLK domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], D};
        end
    end

    assign Q = sync_reg[STAGES-1];

endmodule

// File: rtl/intr_debounce_oneshot.sv
// Debounces a raw interrupt source and emits one request pulse per accepted press.
module intr_debounce_oneshot
    import intr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    input  logic EN,
    output logic INTR_PULSE,
    output logic LEVEL
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_check
        $fatal(1, "intr_debounce_oneshot: DEBOUNCE_CYCLES and SYNC_STAGES must both be >= 2");
    end

    logic             s_in;
    db_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;
    logic             level_reg;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (BTN_IN),
        .Q   (s_in)
    );

    // EN only matters on the DB_PRESS->PRESSED edge; a missed pulse is never replayed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
            level_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s_in) begin
                        state_reg <= DB_PRESS;
                        cnt_reg   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!s_in) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= PRESSED;
                        cnt_reg   <= '0;
                        pulse_reg <= EN;
                        level_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s_in) begin
                        state_reg <= DB_RELEASE;
                        cnt_reg   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (s_in) begin
                        state_reg <= PRESSED;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign INTR_PULSE = pulse_reg;
    assign LEVEL      = level_reg;

endmodule

// File: tb/tb_intr_debounce_oneshot.sv
// Directed bench for intr_debounce_oneshot with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_intr_debounce_oneshot;

    localparam int DB = 4;
    localparam int SS = 2;

    logic CLK = 1'b0;
    logic RST;
    logic BTN_IN;
    logic EN;
    logic INTR_PULSE;
    logic LEVEL;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    intr_debounce_oneshot #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN_IN     (BTN_IN),
        .EN         (EN),
        .INTR_PULSE (INTR_PULSE),
        .LEVEL      (LEVEL)
    );

    // Step index 0 is the first edge that samples the newly driven input.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; BTN_IN = 1'b1; EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold idx=%0d pulse=%b level=%b required 0/0", i, INTR_PULSE, LEVEL);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (INTR_PULSE !== (i == 6)) begin
                bad++;
                $display("FAIL reset_release_pulse idx=%0d got=%b want=%b", i, INTR_PULSE, (i == 6));
            end
            total++;
            if (LEVEL !== (i >= 6)) begin
                bad++;
                $display("FAIL reset_release_level idx=%0d got=%b want=%b", i, LEVEL, (i >= 6));
            end
        end
        BTN_IN = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (LEVEL !== (i < 6) || INTR_PULSE !== 1'b0) begin
                bad++;
                $display("FAIL reset_then_release idx=%0d level=%b pulse=%b want level=%b pulse=0",
                         i, LEVEL, INTR_PULSE, (i < 6));
            end
        end
    endtask

    task automatic test_idle_steady();
        BTN_IN = 1'b0; EN = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== 1'b0) begin
                bad++;
                $display("FAIL idle_steady idx=%0d pulse=%b level=%b required 0/0", i, INTR_PULSE, LEVEL);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses;
        pulses = 0;
        BTN_IN = 1'b1; EN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (INTR_PULSE === 1'b1) pulses++;
            total++;
            if (INTR_PULSE !== (i == 6) || LEVEL !== (i >= 6)) begin
                bad++;
                $display("FAIL clean_press idx=%0d pulse=%b level=%b want pulse=%b level=%b",
                         i, INTR_PULSE, LEVEL, (i == 6), (i >= 6));
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL clean_press_count got=%0d want=1", pulses);
        end
        BTN_IN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== (i < 6)) begin
                bad++;
                $display("FAIL clean_release idx=%0d pulse=%b level=%b want pulse=0 level=%b",
                         i, INTR_PULSE, LEVEL, (i < 6));
            end
        end
    endtask

    task automatic test_bounce();
        logic press_pat [8];
        logic rel_pat [4];
        press_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rel_pat   = '{1'b0, 1'b0, 1'b1, 1'b0};
        EN = 1'b1;
        // Last rising sample at idx 7, so acceptance lands at idx 13.
        for (int i = 0; i < 24; i++) begin
            BTN_IN = (i < 8) ? press_pat[i] : 1'b1;
            step();
            total++;
            if (INTR_PULSE !== (i == 13) || LEVEL !== (i >= 13)) begin
                bad++;
                $display("FAIL bounce_press idx=%0d pulse=%b level=%b want pulse=%b level=%b",
                         i, INTR_PULSE, LEVEL, (i == 13), (i >= 13));
            end
        end
        // Bounce back to PRESSED at idx 4; five clean lows complete at idx 9.
        for (int i = 0; i < 16; i++) begin
            BTN_IN = (i < 4) ? rel_pat[i] : 1'b0;
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== (i < 9)) begin
                bad++;
                $display("FAIL bounce_release idx=%0d pulse=%b level=%b want pulse=0 level=%b",
                         i, INTR_PULSE, LEVEL, (i < 9));
            end
        end
    endtask

    task automatic test_enable();
        BTN_IN = 1'b1; EN = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (i == 6) EN = 1'b1;
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== (i >= 6)) begin
                bad++;
                $display("FAIL enable_gated idx=%0d pulse=%b level=%b want pulse=0 level=%b",
                         i, INTR_PULSE, LEVEL, (i >= 6));
            end
        end
        BTN_IN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== (i < 6)) begin
                bad++;
                $display("FAIL enable_release idx=%0d pulse=%b level=%b want pulse=0 level=%b",
                         i, INTR_PULSE, LEVEL, (i < 6));
            end
        end
        BTN_IN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (INTR_PULSE !== (i == 6) || LEVEL !== (i >= 6)) begin
                bad++;
                $display("FAIL enable_repress idx=%0d pulse=%b level=%b want pulse=%b level=%b",
                         i, INTR_PULSE, LEVEL, (i == 6), (i >= 6));
            end
        end
        BTN_IN = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        BTN_IN = 1'b1; EN = 1'b1;
        // After idx 4 the FSM sits in DB_PRESS with cnt=2.
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (INTR_PULSE !== 1'b0 || LEVEL !== 1'b0) begin
                bad++;
                $display("FAIL mid_pre idx=%0d pulse=%b level=%b required 0/0", i, INTR_PULSE, LEVEL);
            end
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++;
        if (INTR_PULSE !== 1'b0 || LEVEL !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset pulse=%b level=%b required 0/0", INTR_PULSE, LEVEL);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (INTR_PULSE !== (i == 6) || LEVEL !== (i >= 6)) begin
                bad++;
                $display("FAIL mid_after idx=%0d pulse=%b level=%b want pulse=%b level=%b",
                         i, INTR_PULSE, LEVEL, (i == 6), (i >= 6));
            end
        end
        BTN_IN = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_long_hold();
        int pulses;
        int first_pulse;
        int level_drops;
        pulses = 0; first_pulse = -1; level_drops = 0;
        EN = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            BTN_IN = (i == 500 || i == 501) ? 1'b0 : 1'b1;
            step();
            if (INTR_PULSE === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (i >= 6 && LEVEL !== 1'b1) level_drops++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL long_hold_count got=%0d want=1", pulses);
        end
        total++;
        if (first_pulse != 6) begin
            bad++;
            $display("FAIL long_hold_first got=%0d want=6", first_pulse);
        end
        total++;
        if (level_drops != 0) begin
            bad++;
            $display("FAIL long_hold_level drops=%0d want=0", level_drops);
        end
        BTN_IN = 1'b0;
        repeat (8) step();
        total++;
        if (LEVEL !== 1'b0) begin
            bad++;
            $display("FAIL long_hold_release level=%b want=0", LEVEL);
        end
    endtask

    initial begin
        RST = 1'b1; BTN_IN = 1'b0; EN = 1'b1;
        test_reset();
        test_idle_steady();
        test_clean_press();
        test_bounce();
        test_enable();
        test_reset_mid();
        test_long_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_debounce_oneshot.md
Name: intr_debounce_oneshot

Overview:
- Conditions a raw, asynchronous, bouncy interrupt source (push-button or external pin) into a clean single-cycle request pulse.
- INTR_PULSE drives the SET input of the CPU interrupt-request latch directly. The latch holds the request until the control unit clears it.
- Sits immediately upstream of that latch in the top-level wrapper. It has one instance per interrupt source.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles required to accept a level change. Legal range >= 2.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer. Legal range >= 2.

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- BTN_IN  input  1  raw asynchronous interrupt source.
- EN  input  1  interrupt enable. Gates the pulse only; the FSM always runs.
- INTR_PULSE  output  1  one-cycle request pulse to the interrupt latch SET input.
- LEVEL  output  1  debounced level of BTN_IN.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high. RST wins over every other input on the same edge.
- Reset values: synchronizer flops 0, state IDLE, counter 0, INTR_PULSE 0, LEVEL 0.
- Synchronizer: SYNC_STAGES-deep flop chain. The FSM sees only the last stage, called s_in.
- Counter: width $clog2(DEBOUNCE_CYCLES). It never wraps; it is cleared on every state change.
- FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
- IDLE:
  - s_in=1 -> DB_PRESS, cnt<=0.
  - Otherwise stay.
- DB_PRESS:
  - s_in=0 -> IDLE, cnt<=0.
  - s_in=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. On the same edge INTR_PULSE<=EN.
  - Otherwise cnt<=cnt+1.
- PRESSED:
  - s_in=0 -> DB_RELEASE, cnt<=0.
  - Otherwise stay.
- DB_RELEASE:
  - s_in=1 -> PRESSED, cnt<=0, no pulse.
  - s_in=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt<=cnt+1.
- Acceptance rule: a press is accepted after DEBOUNCE_CYCLES+1 consecutive high s_in samples. A release is accepted after DEBOUNCE_CYCLES+1 consecutive low samples.
- Press latency: BTN_IN first sampled high at edge e0 and held. INTR_PULSE and LEVEL go high on edge e0+SYNC_STAGES+DEBOUNCE_CYCLES.
- INTR_PULSE (registered):
  - High for exactly one cycle, on entry to PRESSED from DB_PRESS only.
  - Cleared on the following edge.
  - At most one pulse per accepted press, regardless of hold time.
- EN handling:
  - EN is sampled on the transition edge only.
  - EN=0 at that edge suppresses the pulse permanently. There is no deferred or pending pulse.
  - Raising EN while the source is still held produces nothing.
- No pulse on release, or on a DB_RELEASE->PRESSED bounce.
- LEVEL (registered): 1 in PRESSED and DB_RELEASE, 0 in IDLE and DB_PRESS.
- Reset mid-operation: any state returns to IDLE with all flops cleared. A subsequent press incurs the full latency again.
- Steady-state 0 input: the block stays in IDLE indefinitely with no activity.
- Elaboration guard: DEBOUNCE_CYCLES<2 or SYNC_STAGES<2 is a fatal elaboration error.

Decomposition:
- Package intr_pkg holds:
  - typedef enum logic [1:0] db_state_t {IDLE, DB_PRESS, PRESSED, DB_RELEASE}.
  - Constants DEFAULT_DEBOUNCE_CYCLES=500000 and DEFAULT_SYNC_STAGES=2.
- One sub-module, sync_chain:
  - Parameter STAGES.
  - Ports CLK, RST, D, Q; reset value 0.
  - Reusable for other asynchronous inputs, e.g. switches.
- The FSM, counter and output registers stay in intr_debounce_oneshot.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- Reset: RST=1 for 5 cycles with BTN_IN=1 -> INTR_PULSE=0, LEVEL=0 throughout. Release RST with BTN_IN still 1 -> one pulse on the 6th edge after the first post-reset sampling edge.
- Clean press/release: BTN_IN 0->1 held 20 cycles -> exactly one INTR_PULSE, 6 edges after e0, LEVEL rises on the same edge. BTN_IN->0 held 20 cycles -> LEVEL falls 6 edges later, no pulse.
- Bounce: BTN_IN pattern 1,1,1,0,1,1,0,1 then stable 1 -> no pulse during the bounce. A single pulse arrives 6 edges after the final rising sample. Release bounce 0,0,1,0 then stable 0 -> LEVEL stays 1 until 5 consecutive low s_in samples.
- Enable gating: EN=0 at the acceptance edge -> LEVEL=1, INTR_PULSE=0. EN->1 while held 10 more cycles -> still no pulse. Release, then press again with EN=1 -> one pulse.
- Reset mid-debounce: assert RST for 1 cycle when in DB_PRESS with cnt=2 -> state IDLE, cnt=0. With BTN_IN held, the pulse arrives the full 6 edges after the first post-reset sample.
- Long hold with glitch: hold 1000 cycles, one pulse only. Inject a 2-cycle low glitch mid-hold -> DB_RELEASE then back to PRESSED, LEVEL stays 1, no second pulse.
